// File: rtl/uart_pkg.sv
// Shared types, constants and the baud-divisor helper for the 8N1 UART PHY.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int uart_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_phy_if.sv
// Byte-level handshake between the UART register block (master) and the PHY (slave).
interface uart_phy_if;
    import uart_pkg::*;

    logic                      tx_write;
    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_busy;
    logic                      tx_finished;
    logic                      rx_ready;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_frame_err;

    modport master (
        output tx_write, tx_data,
        input  tx_busy, tx_finished, rx_ready, rx_data, rx_frame_err
    );

    modport slave (
        input  tx_write, tx_data,
        output tx_busy, tx_finished, rx_ready, rx_data, rx_frame_err
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module uart_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign tick = (count_reg == '0);

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART transceiver: independent TX serialiser and RX deserialiser sharing one clock.
module uart_phy import uart_pkg::*; #(
    parameter int CLK_FREQ  = 12000000,
    parameter int UART_FREQ = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    uart_phy_if.slave  bus
);

    localparam int DIV  = uart_div(CLK_FREQ, UART_FREQ);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int IW   = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

    if (DIV < 4) begin : g_bad_div
        $error("uart_phy: bit period must be at least 4 clock cycles");
    end

    // ---------------- TX ----------------
    tx_state_t                 tx_state_reg, tx_state_next;
    logic [UART_DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic [IW-1:0]             tx_idx_reg, tx_idx_next;
    logic                      tx_reg, tx_next;
    logic                      tx_load, tx_tick, tx_fin;

    uart_bit_timer #(.WIDTH(CW)) u_tx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tx_load),
        .load_val (DIV_LOAD),
        .tick     (tx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_idx_reg   <= '0;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_idx_reg   <= tx_idx_next;
            tx_reg       <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_idx_next   = tx_idx_reg;
        tx_load       = 1'b0;
        tx_fin        = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (bus.tx_write) begin
                    tx_shift_next = bus.tx_data;
                    tx_load       = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_load       = 1'b1;
                    tx_idx_next   = '0;
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_load       = 1'b1;
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_idx_reg == IDX_LAST) begin
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_idx_next = tx_idx_reg + IW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_fin        = 1'b1;
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        // Pin level is registered from the upcoming state so the pad never glitches.
        tx_next = 1'b1;
        if (tx_state_next == TX_START) begin
            tx_next = 1'b0;
        end else if (tx_state_next == TX_DATA) begin
            tx_next = tx_shift_next[0];
        end
    end

    assign tx              = tx_reg;
    assign bus.tx_busy     = (tx_state_reg != TX_IDLE);
    assign bus.tx_finished = tx_fin;

    // ---------------- RX ----------------
    logic [UART_SYNC_STAGES-1:0] sync_reg;
    logic                        rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[UART_SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_reg[UART_SYNC_STAGES-1];

    rx_state_t                 rx_state_reg, rx_state_next;
    logic [UART_DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic [UART_DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic [IW-1:0]             rx_idx_reg, rx_idx_next;
    logic                      rx_ready_reg, rx_ready_next;
    logic                      rx_err_reg, rx_err_next;
    logic                      rx_load, rx_tick;
    logic [CW-1:0]             rx_load_val;

    uart_bit_timer #(.WIDTH(CW)) u_rx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tick     (rx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_reg <= RX_IDLE;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_idx_reg   <= '0;
            rx_ready_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            rx_idx_reg   <= rx_idx_next;
            rx_ready_reg <= rx_ready_next;
            rx_err_reg   <= rx_err_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_idx_next   = rx_idx_reg;
        rx_ready_next = 1'b0;
        rx_err_next   = 1'b0;
        rx_load       = 1'b0;
        rx_load_val   = DIV_LOAD;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_load       = 1'b1;
                    rx_load_val   = HALF_LOAD;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Mid-start sample: a high level here was only a glitch.
                if (rx_tick) begin
                    if (rxs) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_load       = 1'b1;
                        rx_idx_next   = '0;
                        rx_state_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_load       = 1'b1;
                    rx_shift_next = {rxs, rx_shift_reg[UART_DATA_BITS-1:1]};
                    if (rx_idx_reg == IDX_LAST) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_idx_next = rx_idx_reg + IW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rxs) begin
                        rx_data_next  = rx_shift_reg;
                        rx_ready_next = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_err_next   = 1'b1;
                        rx_state_next = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rxs) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign bus.rx_ready     = rx_ready_reg;
    assign bus.rx_data      = rx_data_reg;
    assign bus.rx_frame_err = rx_err_reg;

endmodule

// File: tb/tb_uart_phy.sv
// Scoreboard bench for uart_phy at DIV=10: line decoders feed byte queues, tasks check timing.
`timescale 1ns/1ns
module tb_uart_phy;
    import uart_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic tx;

    uart_phy_if bus ();

    uart_phy #(.CLK_FREQ(1000000), .UART_FREQ(100000)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .tx    (tx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rx_fall_cyc = 0;
    int fin_count   = 0;
    int rdy_count   = 0;
    int err_count   = 0;
    bit tx_mon_en   = 1'b1;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Decode the tx pin independently, sampling mid-bit.
    initial begin : tx_monitor
        logic [7:0] tm_byte;
        logic [7:0] tm_exp;
        logic       tm_start_ok, tm_stop_ok;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (5) @(negedge clk);
                tm_start_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    tm_byte[i] = tx;
                end
                repeat (10) @(negedge clk);
                tm_stop_ok = (tx === 1'b1);
                if (tx_mon_en) begin
                    vectors++;
                    if (tx_exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL tx_unexpected_frame: got byte %02h, required no frame", tm_byte);
                    end else begin
                        tm_exp = tx_exp_q.pop_front();
                        if ({tm_start_ok, tm_stop_ok, tm_byte} !== {1'b1, 1'b1, tm_exp}) begin
                            miscompares++;
                            $display("FAIL tx_frame: got start_ok=%b stop_ok=%b byte=%02h, required 1 1 %02h",
                                     tm_start_ok, tm_stop_ok, tm_byte, tm_exp);
                        end else begin
                            $display("tx frame %02h", tm_byte);
                        end
                    end
                end
            end
        end
    end

    initial begin : rx_monitor
        logic [7:0] rm_exp;
        forever begin
            @(negedge clk);
            if (bus.tx_finished === 1'b1) fin_count++;
            if (bus.rx_frame_err === 1'b1) err_count++;
            if (bus.rx_ready === 1'b1 || bus.rx_frame_err === 1'b1) begin
                vectors++;
                if (bus.rx_ready === 1'b1 && bus.rx_frame_err === 1'b1) begin
                    miscompares++;
                    $display("FAIL rx_exclusive: got rx_ready=1 rx_frame_err=1, required not both");
                end
            end
            if (bus.rx_ready === 1'b1) begin
                rdy_count++;
                vectors++;
                if (rx_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_unexpected: got rx_data=%02h, required no byte", bus.rx_data);
                end else begin
                    rm_exp = rx_exp_q.pop_front();
                    if (bus.rx_data !== rm_exp) begin
                        miscompares++;
                        $display("FAIL rx_byte: got %02h, required %02h", bus.rx_data, rm_exp);
                    end else begin
                        $display("rx byte %02h", bus.rx_data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_rx_frame(input logic [7:0] b, input int per, input logic stop_val);
        @(negedge clk);
        rx_fall_cyc = cyc;
        rx = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(per);
        end
        rx = stop_val;
        #(per);
    endtask

    task automatic write_tx(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_write = 1'b1;
        @(negedge clk);
        bus.tx_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({tx, bus.tx_busy, bus.tx_finished, bus.rx_ready, bus.rx_frame_err, bus.rx_data} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_values: got tx=%b busy=%b fin=%b rdy=%b err=%b data=%02h, required 1 0 0 0 0 00",
                     tx, bus.tx_busy, bus.tx_finished, bus.rx_ready, bus.rx_frame_err, bus.rx_data);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx, bus.tx_busy, bus.rx_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_after_reset: got tx=%b busy=%b rdy=%b, required 1 0 0", tx, bus.tx_busy, bus.rx_ready);
        end
    endtask

    task automatic test_tx_single();
        logic [7:0] pat;
        logic       et, eb, ef;
        int         fin0;
        pat  = 8'hA5;
        fin0 = fin_count;
        tx_exp_q.push_back(pat);
        write_tx(pat);
        for (int k = 1; k <= 101; k++) begin
            if (k <= 10)      et = 1'b0;
            else if (k <= 90) et = pat[(k - 11) / 10];
            else              et = 1'b1;
            eb = (k <= 100) ? 1'b1 : 1'b0;
            ef = (k == 100) ? 1'b1 : 1'b0;
            vectors++;
            if ({tx, bus.tx_busy, bus.tx_finished} !== {et, eb, ef}) begin
                miscompares++;
                $display("FAIL tx_single_cycle%0d: got tx/busy/finished=%b%b%b, required %b%b%b",
                         k, tx, bus.tx_busy, bus.tx_finished, et, eb, ef);
            end
            @(negedge clk);
        end
        vectors++;
        if (tx_exp_q.size() != 0 || fin_count - fin0 != 1) begin
            miscompares++;
            $display("FAIL tx_single_done: got pending=%0d finished=%0d, required 0 1", tx_exp_q.size(), fin_count - fin0);
        end
    endtask

    task automatic test_tx_busy_reject();
        int fin0;
        fin0 = fin_count;
        tx_exp_q.push_back(8'h55);
        write_tx(8'h55);
        repeat (29) @(negedge clk);
        vectors++;
        if (bus.tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_at_30: got tx_busy=%b, required 1", bus.tx_busy);
        end
        bus.tx_data  = 8'hFF;
        bus.tx_write = 1'b1;
        @(negedge clk);
        bus.tx_write = 1'b0;
        repeat (69) @(negedge clk);
        vectors++;
        if (bus.tx_finished !== 1'b1) begin
            miscompares++;
            $display("FAIL finished_at_100: got tx_finished=%b, required 1", bus.tx_finished);
        end
        bus.tx_write = 1'b1;
        @(negedge clk);
        bus.tx_write = 1'b0;
        vectors++;
        if ({bus.tx_busy, tx} !== 2'b01) begin
            miscompares++;
            $display("FAIL write_on_finish: got busy=%b tx=%b, required 0 1", bus.tx_busy, tx);
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (tx_exp_q.size() != 0 || fin_count - fin0 != 1 || bus.tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_reject_done: got pending=%0d finished=%0d busy=%b, required 0 1 0",
                     tx_exp_q.size(), fin_count - fin0, bus.tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int fin0;
        fin0 = fin_count;
        tx_exp_q.push_back(8'h12);
        write_tx(8'h12);
        repeat (100) @(negedge clk);
        vectors++;
        if (bus.tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready: got tx_busy=%b at cycle 101, required 0", bus.tx_busy);
        end
        tx_exp_q.push_back(8'h34);
        bus.tx_data  = 8'h34;
        bus.tx_write = 1'b1;
        @(negedge clk);
        bus.tx_write = 1'b0;
        vectors++;
        if ({bus.tx_busy, tx} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b tx=%b, required 1 0", bus.tx_busy, tx);
        end
        repeat (110) @(negedge clk);
        vectors++;
        if (tx_exp_q.size() != 0 || fin_count - fin0 != 2) begin
            miscompares++;
            $display("FAIL b2b_done: got pending=%0d finished=%0d, required 0 2", tx_exp_q.size(), fin_count - fin0);
        end
    endtask

    task automatic test_rx_byte();
        int rdy0, err0, n;
        rdy0 = rdy_count;
        err0 = err_count;
        rx_exp_q.push_back(8'h3C);
        fork
            send_rx_frame(8'h3C, 100, 1'b1);
            begin
                n = 0;
                @(negedge clk);
                while (bus.rx_ready !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                vectors++;
                if (bus.rx_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rx_timeout: got no rx_ready in 200 cycles, required one");
                end else if (cyc - rx_fall_cyc != 98) begin
                    miscompares++;
                    $display("FAIL rx_latency: got %0d cycles, required 98", cyc - rx_fall_cyc);
                end
            end
        join
        repeat (20) @(negedge clk);
        vectors++;
        if (rdy_count - rdy0 != 1 || err_count != err0 || rx_exp_q.size() != 0 || bus.rx_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL rx_byte_done: got ready=%0d err=%0d pending=%0d data=%02h, required 1 0 0 3c",
                     rdy_count - rdy0, err_count - err0, rx_exp_q.size(), bus.rx_data);
        end
    endtask

    task automatic test_rx_glitch_framing();
        int rdy0, err0;
        rdy0 = rdy_count;
        err0 = err_count;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        vectors++;
        if (rdy_count != rdy0 || err_count != err0) begin
            miscompares++;
            $display("FAIL rx_glitch: got ready=%0d err=%0d, required 0 0", rdy_count - rdy0, err_count - err0);
        end
        send_rx_frame(8'hAA, 100, 1'b0);
        repeat (300) @(negedge clk);
        vectors++;
        if (err_count - err0 != 1 || rdy_count != rdy0 || bus.rx_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL rx_break: got err=%0d ready=%0d data=%02h, required 1 0 3c",
                     err_count - err0, rdy_count - rdy0, bus.rx_data);
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rx_exp_q.push_back(8'h81);
        send_rx_frame(8'h81, 100, 1'b1);
        repeat (20) @(negedge clk);
        vectors++;
        if (rdy_count - rdy0 != 1 || err_count - err0 != 1 || rx_exp_q.size() != 0 || bus.rx_data !== 8'h81) begin
            miscompares++;
            $display("FAIL rx_after_break: got ready=%0d err=%0d pending=%0d data=%02h, required 1 1 0 81",
                     rdy_count - rdy0, err_count - err0, rx_exp_q.size(), bus.rx_data);
        end
    endtask

    task automatic test_full_duplex();
        int         fin0, rdy0, err0, n;
        logic [7:0] tb_byte, rb_byte;
        fin0 = fin_count;
        rdy0 = rdy_count;
        err0 = err_count;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    n = 0;
                    while (bus.tx_busy !== 1'b0 && n < 300) begin
                        @(negedge clk);
                        n++;
                    end
                    if (bus.tx_busy !== 1'b0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL duplex_tx_wait: got tx_busy=%b after 300 cycles, required 0", bus.tx_busy);
                    end
                    tb_byte = 8'($urandom_range(0, 255));
                    tx_exp_q.push_back(tb_byte);
                    bus.tx_data  = tb_byte;
                    bus.tx_write = 1'b1;
                    @(negedge clk);
                    bus.tx_write = 1'b0;
                end
            end
            begin
                for (int j = 0; j < 16; j++) begin
                    rb_byte = 8'($urandom_range(0, 255));
                    rx_exp_q.push_back(rb_byte);
                    send_rx_frame(rb_byte, 103, 1'b1);
                end
            end
        join
        repeat (150) @(negedge clk);
        vectors++;
        if (tx_exp_q.size() != 0 || rx_exp_q.size() != 0 || fin_count - fin0 != 16 ||
            rdy_count - rdy0 != 16 || err_count != err0) begin
            miscompares++;
            $display("FAIL duplex_done: got tx_pending=%0d rx_pending=%0d finished=%0d ready=%0d err=%0d, required 0 0 16 16 0",
                     tx_exp_q.size(), rx_exp_q.size(), fin_count - fin0, rdy_count - rdy0, err_count - err0);
        end
    endtask

    task automatic test_reset_mid_tx();
        int fin0;
        tx_mon_en = 1'b0;
        fin0 = fin_count;
        write_tx(8'hC3);
        repeat (44) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({tx, bus.tx_busy, bus.tx_finished} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_mid_tx: got tx=%b busy=%b fin=%b, required 1 0 0", tx, bus.tx_busy, bus.tx_finished);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        vectors++;
        if (fin_count != fin0 || {tx, bus.tx_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_no_finish: got finished=%0d tx=%b busy=%b, required 0 1 0",
                     fin_count - fin0, tx, bus.tx_busy);
        end
        tx_mon_en = 1'b1;
        tx_exp_q.push_back(8'h0F);
        write_tx(8'h0F);
        repeat (110) @(negedge clk);
        vectors++;
        if (tx_exp_q.size() != 0 || fin_count - fin0 != 1) begin
            miscompares++;
            $display("FAIL reset_recover: got pending=%0d finished=%0d, required 0 1", tx_exp_q.size(), fin_count - fin0);
        end
    endtask

    initial begin
        bus.tx_write = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_tx_single();
        test_tx_busy_reject();
        test_back_to_back();
        test_rx_byte();
        test_rx_glitch_framing();
        test_full_duplex();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_phy.md
# uart_phy

Bit-level 8N1 UART transceiver. It serialises bytes handed over by the memory-mapped UART register block and deserialises bytes from the `rx` pin into that block. It sits directly between the register block and the FPGA pins. It owns baud timing, input synchronisation, start/stop validation and per-byte completion strobes.

## Interface
Parameters:
- `CLK_FREQ`, 12000000, system clock in Hz.
- `UART_FREQ`, 115200, baud rate in Hz.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input pin, asynchronous, idle high.
- `tx`  out  1  serial output pin, idle high.
- `rx_ready`  out  1  one-cycle pulse: new byte valid on `rx_data`.
- `rx_data`  out  8  last received byte; held until the next `rx_ready`.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `tx_write`  in  1  one-cycle request to send `tx_data`.
- `tx_data`  in  8  byte to send; sampled only on an accepted `tx_write`.
- `tx_busy`  out  1  high from acceptance until the end of the stop bit.
- `tx_finished`  out  1  one-cycle pulse at the end of the stop bit.

One clock, `clk`. Reset `reset` is asynchronous and active-high.

## Operation
- Bit period: DIV = (CLK_FREQ + UART_FREQ/2) / UART_FREQ, an integer. DIV is 104 at the defaults. HALF = DIV/2.
- Parameter check: DIV < 4 is illegal; elaboration fails.
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM has states IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. On `tx_write`, latch `tx_data` into the shift register and go to START.
  - START: `tx`=0 for DIV cycles.
  - DATA: `tx`=shift[0] for DIV cycles per bit. A 3-bit index counts 0..7, then goes to STOP.
  - STOP: `tx`=1 for DIV cycles. On the last cycle, pulse `tx_finished` and return to IDLE.
- `tx_write` while `tx_busy`=1 is ignored. `tx_data` is not latched and the frame in progress is unaffected.
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All RX logic uses the synchronised signal `rxs`.
- RX FSM has states IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rxs`=0, load the counter and go to START.
  - START: sample after HALF cycles. `rxs`=1 means a glitch: return to IDLE with no output. `rxs`=0 goes to DATA.
  - DATA: sample every DIV cycles, shifting in from the MSB side. After 8 samples go to STOP.
  - STOP: sample after DIV cycles.
    - `rxs`=1: load `rx_data`, pulse `rx_ready`, go to IDLE.
    - `rxs`=0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`=1, then go to IDLE. A break condition therefore produces exactly one error.
- RX and TX are fully independent; simultaneous full-duplex operation is required.

## Timing
- Reset values:
  - Outputs: `tx`=1, `tx_busy`=0, `tx_finished`=0, `rx_ready`=0, `rx_frame_err`=0, `rx_data`=8'h00.
  - Internal: both FSMs IDLE, counters 0.
- Reset mid-frame aborts immediately. `tx` returns high asynchronously and no completion pulse follows.
- TX latency:
  - Write in cycle N: `tx_busy`=1 and `tx`=0 from cycle N+1.
  - `tx_finished` is high in cycle N+10·DIV.
  - `tx_busy` is low from cycle N+10·DIV+1, so the next write is accepted in that cycle.
  - Back-to-back frames therefore have no idle gap.
- `tx_write` in the same cycle as `tx_finished` is ignored, because `tx_busy` is still 1.
- RX latency: `rx_ready` asserts 2 (synchroniser) + 1 + HALF + 9·DIV cycles after the `rx` falling edge. `rx_data` is valid in the same cycle.
- `rx_ready` and `rx_frame_err` are never high together.
- Idle-start resynchronisation: a new start bit is detected in the cycle after the mid-stop sample. This tolerates ±4% baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - TX and RX state enums.
  - `uart_div(clk_freq, baud)` function returning DIV.
  - Constant `UART_DATA_BITS = 8`.
- Sub-module `uart_bit_timer`, instantiated once for TX and once for RX.
  - Down-counter of width $clog2(DIV).
  - Inputs `load` and `load_val`; output `tick` pulses when the count reaches 0.

## Test plan
All scenarios use CLK_FREQ=1000000 and UART_FREQ=100000, so DIV=10 and HALF=5.
- TX single byte: `tx_write` with 8'hA5 at cycle 0.
  - `tx` runs low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles.
  - `tx_finished` in cycle 100; `tx_busy` low in cycle 101.
- TX busy rejection: write 8'h55, then write 8'hFF at cycle 30. The frame on the wire is still 8'h55 and exactly one `tx_finished` follows.
- RX byte: drive frame 8'h3C on `rx` at exact baud. Exactly one `rx_ready` with `rx_data`=8'h3C, and no `rx_frame_err`.
- RX glitch and framing:
  - A 3-cycle low pulse on idle `rx` gives no output.
  - A frame with the stop bit held low gives one `rx_frame_err` and `rx_data` unchanged.
  - Holding `rx` low 300 cycles gives no further error; the next valid 8'h81 is received.
- Full duplex with ±3% skewed RX baud (period 10.3 cycles): 16 random bytes each direction, all received and sent correctly.
- Reset mid-TX at cycle 45 of a frame:
  - `tx`=1 immediately, `tx_busy`=0, no `tx_finished`.
  - After release, a fresh write of 8'h0F is transmitted correctly.
